// File: rtl/gamepad_reader.sv
// rtl/gamepad_reader.sv - serial gamepad poller: latch, clocked shift-in, registered button state
module gamepad_reader #(
  parameter int NUM_BUTTONS  = 8,
  parameter int LATCH_CYCLES = 1200,
  parameter int HALF_PERIOD  = 300,
  parameter int POLL_PERIOD  = 1666667
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   chip_data_raw,
  output logic                   chip_latch_out,
  output logic                   chip_clk_out,
  output logic [NUM_BUTTONS-1:0] buttons_out,
  output logic                   valid_out,
  output logic                   changed_out
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int POLL_W    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int IDX_W     = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [PHASE_W-1:0]      phase_cnt;
  logic [POLL_W-1:0]       poll_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [NUM_BUTTONS-1:0]  shift;
  logic [NUM_BUTTONS-1:0]  shift_d;
  logic                    data_meta;
  logic                    data_sync;
  logic                    first_poll;
  logic                    phase_last;
  logic                    poll_due;
  logic                    sample;
  logic                    latch_d;
  logic                    clk_d;
  logic                    load_d;

  // Line idles high (released), so the synchronizer resets to 1
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= chip_data_raw;
      data_sync <= data_meta;
    end
  end

  always_comb begin
    phase_last = 1'b0;
    if (state == S_LATCH)
      phase_last = (phase_cnt == PHASE_W'(LATCH_CYCLES - 1));
    else
      phase_last = (phase_cnt == PHASE_W'(HALF_PERIOD - 1));
  end

  assign poll_due = first_poll || (poll_cnt == POLL_W'(POLL_PERIOD - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= next_state;
  end

  // DONE may chain straight into LATCH when a transaction outlasts the poll period
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (poll_due) next_state = S_LATCH;
      S_LATCH: if (phase_last) next_state = S_LOW;
      S_LOW: begin
        if (phase_last) begin
          if (bit_idx < IDX_W'(NUM_BUTTONS - 1)) next_state = S_HIGH;
          else                                   next_state = S_DONE;
        end
      end
      S_HIGH:  if (phase_last) next_state = S_LOW;
      S_DONE:  next_state = poll_due ? S_LATCH : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    latch_d = (next_state == S_LATCH);
    clk_d   = (next_state == S_HIGH);
    load_d  = (next_state == S_DONE);
    sample  = (state == S_LOW) && phase_last;
    shift_d = shift;
    if (sample) shift_d[bit_idx] = ~data_sync;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_cnt      <= '0;
      poll_cnt       <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      first_poll     <= 1'b1;
      chip_latch_out <= 1'b0;
      chip_clk_out   <= 1'b0;
      buttons_out    <= '0;
      valid_out      <= 1'b0;
      changed_out    <= 1'b0;
    end else begin
      if ((next_state != state) || (state == S_IDLE)) phase_cnt <= '0;
      else                                            phase_cnt <= phase_cnt + PHASE_W'(1);

      // Poll counter runs across the whole transaction and saturates rather than wrapping
      if ((state != S_LATCH) && (next_state == S_LATCH))  poll_cnt <= '0;
      else if (poll_cnt != POLL_W'(POLL_PERIOD - 1))      poll_cnt <= poll_cnt + POLL_W'(1);

      if (next_state == S_LATCH) first_poll <= 1'b0;

      if (state == S_LATCH)                bit_idx <= '0;
      else if (state == S_HIGH && phase_last) bit_idx <= bit_idx + IDX_W'(1);

      shift          <= shift_d;
      chip_latch_out <= latch_d;
      chip_clk_out   <= clk_d;
      valid_out      <= load_d;
      changed_out    <= load_d && (shift_d != buttons_out);
      if (load_d) buttons_out <= shift_d;
    end
  end

endmodule

// File: tb/tb_gamepad_reader.sv
// tb/tb_gamepad_reader.sv - directed table-driven bench for gamepad_reader
module tb_gamepad_reader;

  localparam int NB      = 8;
  localparam int LC      = 8;
  localparam int HP      = 4;
  localparam int PP      = 200;
  localparam int PPB     = 50;
  localparam int T_VALID = 68;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic          a_data, a_latch, a_clk, a_valid, a_changed;
  logic [NB-1:0] a_buttons;
  logic          b_latch, b_clk, b_valid, b_changed;
  logic [NB-1:0] b_buttons;
  logic          b_data = 1'b0;

  gamepad_reader #(.NUM_BUTTONS(NB), .LATCH_CYCLES(LC), .HALF_PERIOD(HP), .POLL_PERIOD(PP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .chip_data_raw(a_data),
    .chip_latch_out(a_latch), .chip_clk_out(a_clk), .buttons_out(a_buttons),
    .valid_out(a_valid), .changed_out(a_changed)
  );

  gamepad_reader #(.NUM_BUTTONS(NB), .LATCH_CYCLES(LC), .HALF_PERIOD(HP), .POLL_PERIOD(PPB)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .chip_data_raw(b_data),
    .chip_latch_out(b_latch), .chip_clk_out(b_clk), .buttons_out(b_buttons),
    .valid_out(b_valid), .changed_out(b_changed)
  );

  // Controller model: latch reloads, each rising shift clock advances, wire low = pressed
  logic [NB-1:0] ctrl_buttons = '0;
  logic [3:0]    ctrl_idx = '0;
  logic          ctrl_prev_clk = 1'b0;
  logic [2:0]    ctrl_sel;
  always @(posedge clk_in) begin
    if (a_latch)                      ctrl_idx <= '0;
    else if (a_clk && !ctrl_prev_clk) ctrl_idx <= ctrl_idx + 4'd1;
    ctrl_prev_clk <= a_clk;
  end
  assign ctrl_sel = ctrl_idx[2:0];
  assign a_data   = (ctrl_idx < 4'd8) ? ~ctrl_buttons[ctrl_sel] : 1'b1;

  int cyc = 0;
  int a_start = 0, a_prev_start = 0, a_latch_len = 0, a_edges = 0;
  int a_overlap = 0, a_valid_cnt = 0;
  logic a_prev_latch = 1'b0, a_prev_clk = 1'b0;
  int b_edges = 0, b_last_valid = 0, b_valid_cnt = 0, b_gap_checks = 0;
  int b_bad_gap = 0, b_bad_edges = 0, b_bad_data = 0, b_overlap = 0, b_first_changed = 0;
  logic b_have_valid = 1'b0, b_prev_latch = 1'b0, b_prev_clk = 1'b0;

  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (a_latch && a_clk) a_overlap <= a_overlap + 1;
    if (a_latch && !a_prev_latch) begin
      a_prev_start <= a_start;
      a_start      <= cyc + 1;
      a_latch_len  <= 1;
      a_edges      <= 0;
    end else begin
      if (a_latch) a_latch_len <= a_latch_len + 1;
      if (a_clk && !a_prev_clk) a_edges <= a_edges + 1;
    end
    if (a_valid) a_valid_cnt <= a_valid_cnt + 1;
    a_prev_latch <= a_latch;
    a_prev_clk   <= a_clk;

    if (b_latch && b_clk) b_overlap <= b_overlap + 1;
    if (rst_in) begin
      b_have_valid <= 1'b0;
    end else begin
      if (b_latch && !b_prev_latch) begin
        b_edges <= 0;
        if (b_have_valid) begin
          b_gap_checks <= b_gap_checks + 1;
          if (cyc != b_last_valid) b_bad_gap <= b_bad_gap + 1;
        end
      end else if (b_clk && !b_prev_clk) begin
        b_edges <= b_edges + 1;
      end
      if (b_valid) begin
        b_valid_cnt  <= b_valid_cnt + 1;
        b_have_valid <= 1'b1;
        b_last_valid <= cyc + 1;
        if (b_edges != 7) b_bad_edges <= b_bad_edges + 1;
        if (b_buttons != 8'hFF) b_bad_data <= b_bad_data + 1;
        if (b_changed && b_have_valid) b_first_changed <= b_first_changed + 1;
      end
    end
    b_prev_latch <= b_latch;
    b_prev_clk   <= b_clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (a_valid) begin
        ok = 1'b1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s: valid_out not seen within 400 cycles, expected a pulse", name);
  endtask

  typedef struct {
    logic [NB-1:0] pat;
    logic [NB-1:0] exp_buttons;
    logic          exp_changed;
  } vec_t;

  vec_t vecs[6];
  bit   ok;
  int   vcnt;

  initial begin
    vecs[0] = '{8'h55, 8'h55, 1'b1};
    vecs[1] = '{8'h55, 8'h55, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1};
    vecs[3] = '{8'h01, 8'h01, 1'b1};
    vecs[4] = '{8'h01, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b1};

    repeat (3) step();
    check("rst_latch",   a_latch,   0);
    check("rst_clk",     a_clk,     0);
    check("rst_buttons", a_buttons, 0);
    check("rst_valid",   a_valid,   0);
    check("rst_changed", a_changed, 0);

    for (int i = 0; i < 6; i++) begin
      ctrl_buttons = vecs[i].pat;
      if (i == 0) begin
        rst_in = 1'b0;
        step();
        check("first_latch_after_release", a_latch, 1);
        check("first_latch_cycle", a_start, cyc);
      end
      wait_valid($sformatf("poll%0d_valid", i), ok);
      if (ok) begin
        check($sformatf("poll%0d_buttons", i), a_buttons, vecs[i].exp_buttons);
        check($sformatf("poll%0d_changed", i), a_changed, vecs[i].exp_changed);
        check($sformatf("poll%0d_latency", i), cyc - a_start, T_VALID);
        check($sformatf("poll%0d_latch_len", i), a_latch_len, LC);
        check($sformatf("poll%0d_clk_edges", i), a_edges, 7);
        if (i > 0) check($sformatf("poll%0d_period", i), a_start - a_prev_start, PP);
        step();
        check($sformatf("poll%0d_valid_pulse", i), a_valid, 0);
        check($sformatf("poll%0d_hold", i), a_buttons, vecs[i].exp_buttons);
      end
    end

    // Abort a poll 40 cycles in with reset, then confirm a fresh poll follows release
    ctrl_buttons = 8'hAA;
    for (int n = 0; n < 300 && !(a_latch && a_start == cyc); n++) step();
    check("abort_latch_seen", a_latch, 1);
    repeat (40) step();
    rst_in = 1'b1;
    #1;
    check("abort_latch",   a_latch,   0);
    check("abort_clk",     a_clk,     0);
    check("abort_buttons", a_buttons, 0);
    check("abort_valid",   a_valid,   0);
    check("abort_changed", a_changed, 0);
    vcnt = a_valid_cnt;
    repeat (5) step();
    check("abort_no_valid", a_valid_cnt, vcnt);
    rst_in = 1'b0;
    step();
    check("restart_latch", a_latch, 1);
    check("restart_cycle", a_start, cyc);
    wait_valid("restart_valid", ok);
    if (ok) begin
      check("restart_buttons", a_buttons, 8'hAA);
      check("restart_changed", a_changed, 1);
      check("restart_latency", cyc - a_start, T_VALID);
      check("restart_clk_edges", a_edges, 7);
    end
    repeat (20) step();

    check("a_never_overlap", a_overlap, 0);
    check("b_never_overlap", b_overlap, 0);
    check("b_enough_polls", b_valid_cnt > 10, 1);
    check("b_gap_checked", b_gap_checks > 8, 1);
    check("b_latch_after_done", b_bad_gap, 0);
    check("b_clk_edges", b_bad_edges, 0);
    check("b_buttons", b_bad_data, 0);
    check("b_unchanged_repeat", b_first_changed, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
